// File: rtl/coherent_bus_ctrl.sv
// coherent_bus_ctrl: round-robin coherent arbiter between CPUS L1 caches and one single-ported RAM
//   CLK, nRST                            clock, asynchronous active-low reset
//   iREN, iaddr -> iwait, iload          per-core instruction fetch
//   dREN, dWEN, daddr, dstore -> dwait, dload   per-core block read / write-back
//   ccwrite, cctrans -> ccwait, ccinv, ccsnoopaddr   snoop side; dstore of the supplier feeds C2C
//   ramstate, ramload -> ramREN, ramWEN, ramaddr, ramstore   RAM port
module coherent_bus_ctrl #(
  parameter int CPUS = 2,
  parameter int BLKWORDS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS*32-1:0]   iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*32-1:0]   dload,
  input  logic [CPUS-1:0]      ccwrite,
  input  logic [CPUS-1:0]      cctrans,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*32-1:0]   ccsnoopaddr,
  input  logic [1:0]           ramstate,
  input  logic [31:0]          ramload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore
);
  localparam int GW = $clog2(CPUS);
  localparam int WW = $clog2(BLKWORDS) + 1;
  localparam logic [1:0] ACCESS = 2'b10;
  typedef enum logic [2:0] {IDLE, IFETCH, SNOOP, C2C, M2C, WB, INV} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, sup_q, sup_d, last_q, last_d, win, sup_sel;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [CPUS-1:0] dreq, oth;
  logic [31:0] g_iaddr, g_daddr, g_dstore, s_dstore;
  logic acc, last_word, sup_hit, snp, word;
  // Scan far-to-near so the requester closest after ptr is the last (winning) assignment.
  function automatic logic [GW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [GW-1:0] ptr);
    logic [GW-1:0] p;
    p = ptr;
    for (int i = CPUS; i >= 1; i--)
      if (req[(int'(ptr) + i) % CPUS]) p = GW'((int'(ptr) + i) % CPUS);
    return p;
  endfunction
  assign dreq = dREN | dWEN | ccwrite;
  assign win = rr_pick(|dreq ? dreq : iREN, last_q);
  assign acc = ramstate == ACCESS;
  assign last_word = wcnt_q + 1'b1 == WW'(BLKWORDS);
  assign oth = ~(CPUS'(1) << gnt_q);
  assign g_iaddr = iaddr[32*gnt_q +: 32];
  assign g_daddr = daddr[32*gnt_q +: 32];
  assign g_dstore = dstore[32*gnt_q +: 32];
  assign s_dstore = dstore[32*sup_q +: 32];
  always_comb begin
    sup_sel = '0;
    sup_hit = 1'b0;
    for (int k = CPUS - 1; k >= 0; k--)
      if (cctrans[k] && k != int'(gnt_q)) begin
        sup_sel = GW'(k);
        sup_hit = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    sup_d = sup_q;
    last_d = last_q;
    wcnt_d = wcnt_q;
    iwait = '1;
    iload = '0;
    dwait = '1;
    dload = '0;
    ccwait = '0;
    ccinv = '0;
    ccsnoopaddr = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    snp = 1'b0;
    word = 1'b0;
    case (state_q)
      IDLE: if (|dreq || |iREN) begin
        gnt_d = win;
        last_d = win;
        wcnt_d = '0;
        state_d = dWEN[win] ? WB : dREN[win] ? SNOOP : ccwrite[win] ? INV : IFETCH;
      end
      IFETCH: begin
        ramREN = 1'b1;
        ramaddr = g_iaddr;
        if (acc) begin
          iload[32*gnt_q +: 32] = ramload;
          iwait[gnt_q] = 1'b0;
          state_d = IDLE;
        end
      end
      SNOOP: begin
        ccwait = oth;
        ccinv = ccwrite[gnt_q] ? oth : '0;
        snp = 1'b1;
        sup_d = sup_sel;
        state_d = sup_hit ? C2C : M2C;
      end
      C2C: begin
        ccwait = oth;
        ccinv[sup_q] = ccwrite[gnt_q];
        snp = 1'b1;
        word = 1'b1;
        ramWEN = 1'b1;
        ramaddr = g_daddr;
        ramstore = s_dstore;
        dload[32*gnt_q +: 32] = s_dstore;
        dwait[sup_q] = ~acc;
      end
      M2C: begin
        ccwait = oth;
        word = 1'b1;
        ramREN = 1'b1;
        ramaddr = g_daddr;
        dload[32*gnt_q +: 32] = acc ? ramload : '0;
      end
      WB: begin
        word = 1'b1;
        ramWEN = 1'b1;
        ramaddr = g_daddr;
        ramstore = g_dstore;
      end
      INV: begin
        ccwait = oth;
        ccinv = oth;
        snp = 1'b1;
        dwait[gnt_q] = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every cycle a word completes, the requester sees dwait low and the counter advances.
    if (word && acc) begin
      dwait[gnt_q] = 1'b0;
      wcnt_d = wcnt_q + 1'b1;
      state_d = last_word ? IDLE : state_q;
    end
    for (int k = 0; k < CPUS; k++)
      if (snp && oth[k]) ccsnoopaddr[32*k +: 32] = g_daddr;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q <= IDLE;
      gnt_q <= '0;
      sup_q <= '0;
      last_q <= GW'(CPUS - 1);
      wcnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sup_q <= sup_d;
      last_q <= last_d;
      wcnt_q <= wcnt_d;
    end
endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// tb_coherent_bus_ctrl: scoreboard bench for coherent_bus_ctrl with CPUS=4, BLKWORDS=2
module tb_coherent_bus_ctrl;
  localparam int N = 4;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [N-1:0] iREN = '0, dREN = '0, dWEN = '0, ccwrite = '0, cctrans = '0;
  logic [N*32-1:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [N-1:0] iwait, dwait, ccwait, ccinv;
  logic [N*32-1:0] iload, dload, ccsnoopaddr;
  logic [1:0] ramstate = ACCESS;
  logic [31:0] ramload, ramaddr, ramstore;
  logic ramREN, ramWEN;
  logic use_fix = 1'b0;
  logic [31:0] fix_val = '0;
  int errors = 0;
  int checks = 0;
  typedef struct {
    int core;
    bit ins;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int left [N];
  int wc [N];
  bit pend [N];
  logic [31:0] nb [N];
  coherent_bus_ctrl #(.CPUS(N), .BLKWORDS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramstate(ramstate), .ramload(ramload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore)
  );
  always #5 CLK = ~CLK;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction
  assign ramload = use_fix ? fix_val : memf(ramaddr);
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic smp();
    @(negedge CLK);
  endtask
  task automatic push(input int c, input bit i, input logic [31:0] d);
    exp_t x;
    x.core = c;
    x.ins = i;
    x.data = d;
    exp_q.push_back(x);
  endtask
  // Behaves like the caches: advances the word address after each accepted word,
  // drops the request after the last word and re-raises it a cycle later if more blocks remain.
  task automatic serve(input int budget);
    int n = 0;
    bit dd [N];
    bit id [N];
    logic [31:0] got;
    while ((exp_q.size() != 0 || dREN != 0 || iREN != 0) && n < budget) begin
      n++;
      smp();
      for (int k = 0; k < N; k++) begin
        dd[k] = dREN[k] && !dwait[k];
        id[k] = iREN[k] && !iwait[k];
        if (dd[k] || id[k]) begin
          got = id[k] ? iload[32*k +: 32] : dload[32*k +: 32];
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL serve_extra: core%0d ins=%0b got %h, nothing expected", k, id[k], got);
          end else begin
            e = exp_q.pop_front();
            if (e.core != k || e.ins != id[k] || e.data !== got) begin
              errors++;
              $display("FAIL serve_word: got core%0d ins=%0b %h, want core%0d ins=%0b %h",
                       k, id[k], got, e.core, e.ins, e.data);
            end
          end
        end
      end
      tick();
      for (int k = 0; k < N; k++) begin
        if (pend[k]) begin
          pend[k] = 1'b0;
          dREN[k] = 1'b1;
          daddr[32*k +: 32] = nb[k];
        end
        if (id[k]) iREN[k] = 1'b0;
        if (dd[k]) begin
          daddr[32*k +: 32] = daddr[32*k +: 32] + 32'd4;
          wc[k]++;
          if (wc[k] == 2) begin
            wc[k] = 0;
            dREN[k] = 1'b0;
            left[k]--;
            pend[k] = left[k] > 0;
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || dREN != 0 || iREN != 0) begin
      errors++;
      $display("FAIL serve_timeout: %0d words outstanding, dREN=%b iREN=%b, want 0", exp_q.size(), dREN, iREN);
    end
  endtask
  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) smp();
    checks++;
    if (iwait !== 4'hF || dwait !== 4'hF) begin
      errors++;
      $display("FAIL reset_wait: iwait=%h dwait=%h, want f f", iwait, dwait);
    end
    checks++;
    if (ccwait !== 4'h0 || ccinv !== 4'h0 || ccsnoopaddr !== '0) begin
      errors++;
      $display("FAIL reset_cc: ccwait=%h ccinv=%h snoop=%h, want 0", ccwait, ccinv, ccsnoopaddr);
    end
    checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== '0 || ramstore !== '0) begin
      errors++;
      $display("FAIL reset_ram: ren=%b wen=%b addr=%h store=%h, want 0", ramREN, ramWEN, ramaddr, ramstore);
    end
    checks++;
    if (iload !== '0 || dload !== '0) begin
      errors++;
      $display("FAIL reset_load: iload=%h dload=%h, want 0", iload, dload);
    end
    tick();
    nRST = 1'b1;
  endtask
  task automatic test_round_robin();
    left = '{2, 1, 0, 1};
    nb[0] = 32'h1000;
    daddr = {32'h3000, 32'h0, 32'h2000, 32'h0};
    dREN = 4'b1011;
    push(0, 0, memf(32'h0));
    push(0, 0, memf(32'h4));
    push(1, 0, memf(32'h2000));
    push(1, 0, memf(32'h2004));
    push(3, 0, memf(32'h3000));
    push(3, 0, memf(32'h3004));
    push(0, 0, memf(32'h1000));
    push(0, 0, memf(32'h1004));
    serve(80);
  endtask
  task automatic test_ifetch();
    iaddr[95:64] = 32'h40;
    iREN = 4'b0100;
    use_fix = 1'b1;
    fix_val = 32'h8C010004;
    push(2, 1, 32'h8C010004);
    smp();
    checks++;
    if (iwait !== 4'hF || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_arb: iwait=%h ramREN=%b, want f 0", iwait, ramREN);
    end
    tick();
    smp();
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin
      errors++;
      $display("FAIL ifetch_ram: ramREN=%b ramaddr=%h, want 1 00000040", ramREN, ramaddr);
    end
    checks++;
    if (iwait !== 4'b1011) begin
      errors++;
      $display("FAIL ifetch_iwait: iwait=%b, want 1011", iwait);
    end
    e = exp_q.pop_front();
    checks++;
    if (iload !== {32'h0, e.data, 64'h0}) begin
      errors++;
      $display("FAIL ifetch_iload: iload=%h, want %h in core2 slot", iload, e.data);
    end
    tick();
    iREN = '0;
    use_fix = 1'b0;
    smp();
    checks++;
    if (iwait !== 4'hF || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL ifetch_done: iwait=%h ramREN=%b, want f 0", iwait, ramREN);
    end
    tick();
  endtask
  task automatic test_c2c();
    daddr[63:32] = 32'h100;
    dREN = 4'b0010;
    cctrans = 4'b1000;
    dstore[127:96] = 32'hDEADBEEF;
    push(1, 0, 32'hDEADBEEF);
    push(1, 0, 32'hDEADBEEF);
    smp();
    tick();
    smp();
    checks++;
    if (ccsnoopaddr !== {32'h100, 32'h100, 32'h0, 32'h100}) begin
      errors++;
      $display("FAIL c2c_snoopaddr: got %h, want 100 to cores 0,2,3", ccsnoopaddr);
    end
    checks++;
    if (ccwait !== 4'b1101 || ccinv !== 4'b0000 || dwait !== 4'hF) begin
      errors++;
      $display("FAIL c2c_snoop: ccwait=%b ccinv=%b dwait=%b, want 1101 0000 1111", ccwait, ccinv, dwait);
    end
    tick();
    cctrans = '0;
    for (int w = 0; w < 2; w++) begin
      smp();
      e = exp_q.pop_front();
      checks++;
      if (ramWEN !== 1'b1 || ramaddr !== 32'h100 + 32'(4 * w) || ramstore !== e.data || dload[63:32] !== e.data) begin
        errors++;
        $display("FAIL c2c_data: wen=%b addr=%h store=%h dload1=%h, want 1 %h %h %h",
                 ramWEN, ramaddr, ramstore, dload[63:32], 32'h100 + 32'(4 * w), e.data, e.data);
      end
      checks++;
      if (dwait !== 4'b0101 || ccwait !== 4'b1101) begin
        errors++;
        $display("FAIL c2c_wait: dwait=%b ccwait=%b, want 0101 1101", dwait, ccwait);
      end
      tick();
      daddr[63:32] = daddr[63:32] + 32'd4;
      if (w == 1) dREN = '0;
    end
    smp();
    checks++;
    if (dwait !== 4'hF || ramWEN !== 1'b0 || ccwait !== 4'h0) begin
      errors++;
      $display("FAIL c2c_done: dwait=%b wen=%b ccwait=%b, want 1111 0 0000", dwait, ramWEN, ccwait);
    end
    tick();
  endtask
  task automatic test_rfo();
    daddr[31:0] = 32'h200;
    dREN = 4'b0001;
    ccwrite = 4'b0001;
    cctrans = 4'b0110;
    dstore[63:32] = 32'h11111111;
    dstore[95:64] = 32'h22222222;
    push(0, 0, 32'h11111111);
    push(0, 0, 32'h11111111);
    smp();
    tick();
    smp();
    checks++;
    if (ccinv !== 4'b1110 || ccwait !== 4'b1110 || ccsnoopaddr !== {32'h200, 32'h200, 32'h200, 32'h0}) begin
      errors++;
      $display("FAIL rfo_snoop: ccinv=%b ccwait=%b snoop=%h, want 1110 1110 200 to cores 1-3", ccinv, ccwait, ccsnoopaddr);
    end
    tick();
    cctrans = '0;
    for (int w = 0; w < 2; w++) begin
      smp();
      e = exp_q.pop_front();
      checks++;
      if (ccinv !== 4'b0010 || dwait !== 4'b1100) begin
        errors++;
        $display("FAIL rfo_c2c_ctl: ccinv=%b dwait=%b, want 0010 1100", ccinv, dwait);
      end
      checks++;
      if (ramWEN !== 1'b1 || ramstore !== e.data || dload[31:0] !== e.data) begin
        errors++;
        $display("FAIL rfo_c2c_data: wen=%b store=%h dload0=%h, want 1 %h %h", ramWEN, ramstore, dload[31:0], e.data, e.data);
      end
      tick();
      daddr[31:0] = daddr[31:0] + 32'd4;
      if (w == 1) begin
        dREN = '0;
        ccwrite = '0;
      end
    end
    smp();
    checks++;
    if (ccinv !== 4'h0 || dwait !== 4'hF) begin
      errors++;
      $display("FAIL rfo_done: ccinv=%b dwait=%b, want 0000 1111", ccinv, dwait);
    end
    tick();
  endtask
  task automatic test_inv();
    daddr[95:64] = 32'h300;
    ccwrite = 4'b0100;
    smp();
    tick();
    smp();
    checks++;
    if (ccinv !== 4'b1011 || ccwait !== 4'b1011) begin
      errors++;
      $display("FAIL inv_cc: ccinv=%b ccwait=%b, want 1011 1011", ccinv, ccwait);
    end
    checks++;
    if (ccsnoopaddr !== {32'h300, 32'h0, 32'h300, 32'h300}) begin
      errors++;
      $display("FAIL inv_addr: snoop=%h, want 300 to cores 0,1,3", ccsnoopaddr);
    end
    checks++;
    if (dwait !== 4'b1011 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
      errors++;
      $display("FAIL inv_ack: dwait=%b ren=%b wen=%b, want 1011 0 0", dwait, ramREN, ramWEN);
    end
    tick();
    ccwrite = '0;
    smp();
    checks++;
    if (ccinv !== 4'h0 || ccwait !== 4'h0 || dwait !== 4'hF) begin
      errors++;
      $display("FAIL inv_done: ccinv=%b ccwait=%b dwait=%b, want 0000 0000 1111", ccinv, ccwait, dwait);
    end
    tick();
  endtask
  task automatic test_wb();
    daddr[31:0] = 32'h500;
    dstore[31:0] = 32'hCAFE0000;
    dWEN = 4'b0001;
    ramstate = BUSY;
    push(0, 0, 32'hCAFE0000);
    smp();
    for (int b = 0; b < 3; b++) begin
      tick();
      smp();
      checks++;
      if (ramWEN !== 1'b1 || ramaddr !== 32'h500 || dwait !== 4'hF) begin
        errors++;
        $display("FAIL wb_busy%0d: wen=%b addr=%h dwait=%b, want 1 500 1111", b, ramWEN, ramaddr, dwait);
      end
    end
    tick();
    ramstate = ACCESS;
    smp();
    e = exp_q.pop_front();
    checks++;
    if (ramWEN !== 1'b1 || dwait !== 4'b1110 || ramstore !== e.data) begin
      errors++;
      $display("FAIL wb_access: wen=%b dwait=%b store=%h, want 1 1110 %h", ramWEN, dwait, ramstore, e.data);
    end
    tick();
    daddr[31:0] = 32'h504;
    dstore[31:0] = 32'hCAFE0001;
    ramstate = BUSY;
    smp();
    checks++;
    if (ramWEN !== 1'b1 || ramaddr !== 32'h504 || ramstore !== 32'hCAFE0001 || dwait !== 4'hF) begin
      errors++;
      $display("FAIL wb_word2: wen=%b addr=%h store=%h dwait=%b, want 1 504 cafe0001 1111", ramWEN, ramaddr, ramstore, dwait);
    end
    #1 nRST = 1'b0;
    #1;
    checks++;
    if (ramWEN !== 1'b0 || ramaddr !== '0 || ramstore !== '0 || dwait !== 4'hF || ccwait !== 4'h0) begin
      errors++;
      $display("FAIL wb_reset: wen=%b addr=%h store=%h dwait=%b ccwait=%b, want 0 0 0 1111 0000",
               ramWEN, ramaddr, ramstore, dwait, ccwait);
    end
    tick();
    dWEN = '0;
    ramstate = ACCESS;
    nRST = 1'b1;
    smp();
    checks++;
    if (ramWEN !== 1'b0 || ramREN !== 1'b0 || dwait !== 4'hF) begin
      errors++;
      $display("FAIL wb_after: wen=%b ren=%b dwait=%b, want 0 0 1111", ramWEN, ramREN, dwait);
    end
    tick();
  endtask
  task automatic test_back_to_back();
    daddr[63:32] = 32'h600;
    iaddr[63:32] = 32'h80;
    left[1] = 1;
    dREN = 4'b0010;
    iREN = 4'b0010;
    push(1, 0, memf(32'h600));
    push(1, 0, memf(32'h604));
    push(1, 1, memf(32'h80));
    serve(40);
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_ifetch();
    test_c2c();
    test_rfo();
    test_inv();
    test_wb();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected words never produced, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
